// File: rtl/imem_boot_loader_pkg.sv
// Shared definitions for the boot-loadable instruction memory: NOP word, FSM states,
// fetch response bundle and the address legality rule used by both fetch and load paths.
package imem_boot_loader_pkg;

  localparam logic [31:0] NOP_WORD_DEFAULT = 32'h0000_0013;

  typedef enum logic {
    ST_BOOT = 1'b0,
    ST_RUN  = 1'b1
  } boot_state_e;

  typedef struct packed {
    logic [31:0] data;
    logic        valid;
    logic        fault;
  } fetch_rsp_t;

  // Callers zero-extend their byte address to 64 bits so the range compare is
  // done at full width and a large address can never alias back into the array.
  function automatic logic addr_ok(input logic [63:0] byte_addr,
                                   input int unsigned depth_words);
    return (byte_addr[1:0] == 2'b00) && ((byte_addr >> 2) < 64'(depth_words));
  endfunction

endpackage

// File: rtl/imem_boot_fsm.sv
// Load-then-run controller: owns the BOOT/RUN state, the saturating load counter
// and the sticky dropped-word flag, and issues the array write enable.
module imem_boot_fsm
  import imem_boot_loader_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 64,
  parameter int unsigned CNT_W       = $clog2(DEPTH_WORDS + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ld_valid_i,
  input  logic             ld_addr_ok_i,
  input  logic             ld_last_i,
  input  logic             reload_i,
  output boot_state_e      state_o,
  output logic             ld_ready_o,
  output logic             boot_done_o,
  output logic             ld_err_o,
  output logic [CNT_W-1:0] ld_count_o,
  output logic             wr_en_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEPTH_WORDS);

  boot_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of every other flop, independent of block ordering.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_BOOT;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  // NOTE: every output of this block is given a default first, so no path
  // leaves a variable unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    wr_en_o = 1'b0;
    case (state_q)
      ST_BOOT: begin
        if (ld_valid_i) begin
          if (ld_addr_ok_i) begin
            wr_en_o = !reset;
            cnt_d   = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
          end else begin
            err_d = 1'b1;
          end
          // A dropped final beat still ends the image.
          if (ld_last_i) state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (reload_i) begin
          state_d = ST_BOOT;
          cnt_d   = '0;
          err_d   = 1'b0;
        end
      end
    endcase
  end

  assign state_o     = state_q;
  assign ld_ready_o  = (state_q == ST_BOOT);
  assign boot_done_o = (state_q == ST_RUN);
  assign ld_err_o    = err_q;
  assign ld_count_o  = cnt_q;

endmodule

// File: rtl/imem_boot_loader.sv
// Instruction memory for the RV32I core with a run-time boot-load port, fault
// detection on fetch and a generate-selected combinational or registered read.
module imem_boot_loader
  import imem_boot_loader_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS  = 64,
  parameter int unsigned ADDR_W       = 32,
  parameter int unsigned READ_LATENCY = 0,
  parameter logic [31:0] NOP_WORD     = NOP_WORD_DEFAULT
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic [ADDR_W-1:0]                    pc,
  input  logic                                 fetch_req,
  output logic [31:0]                          instruction_code,
  output logic                                 instr_valid,
  output logic                                 fetch_fault,
  input  logic                                 ld_valid,
  output logic                                 ld_ready,
  input  logic [ADDR_W-1:0]                    ld_addr,
  input  logic [31:0]                          ld_data,
  input  logic                                 ld_last,
  input  logic                                 reload,
  output logic                                 boot_done,
  output logic                                 ld_err,
  output logic [$clog2(DEPTH_WORDS + 1)-1:0]   ld_count
);

  localparam int unsigned IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  boot_state_e      state;
  logic             wr_en;
  logic             ld_ok, fetch_ok;
  logic [IDX_W-1:0] ld_idx, fetch_idx;
  logic [31:0]      mem_q [DEPTH_WORDS];
  fetch_rsp_t       rsp_now;

  assign ld_ok     = addr_ok(64'(ld_addr), DEPTH_WORDS);
  assign fetch_ok  = addr_ok(64'(pc), DEPTH_WORDS);
  assign ld_idx    = ld_addr[IDX_W+1:2];
  assign fetch_idx = pc[IDX_W+1:2];

  imem_boot_fsm #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .CNT_W       ($clog2(DEPTH_WORDS + 1))
  ) u_fsm (
    .clk          (clk),
    .reset        (reset),
    .ld_valid_i   (ld_valid),
    .ld_addr_ok_i (ld_ok),
    .ld_last_i    (ld_last),
    .reload_i     (reload),
    .state_o      (state),
    .ld_ready_o   (ld_ready),
    .boot_done_o  (boot_done),
    .ld_err_o     (ld_err),
    .ld_count_o   (ld_count),
    .wr_en_o      (wr_en)
  );

  // NOTE: the array has no reset branch on purpose: a loaded image must survive
  // reset, and leaving it out lets the storage map onto plain RAM.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[ld_idx] <= ld_data;
  end

  always_comb begin
    rsp_now = '{data: NOP_WORD, valid: 1'b0, fault: 1'b0};
    if (fetch_req && (state == ST_RUN)) begin
      if (fetch_ok) begin
        rsp_now.data  = mem_q[fetch_idx];
        rsp_now.valid = 1'b1;
      end else begin
        rsp_now.fault = 1'b1;
      end
    end
  end

  generate
    if (READ_LATENCY == 0) begin : g_comb_read
      assign instruction_code = rsp_now.data;
      assign instr_valid      = rsp_now.valid;
      assign fetch_fault      = rsp_now.fault;
    end else begin : g_reg_read
      fetch_rsp_t rsp_q, rsp_d;

      // Flags follow every cycle; the word only updates on a request so it holds when idle.
      always_comb begin
        rsp_d       = rsp_q;
        rsp_d.valid = rsp_now.valid;
        rsp_d.fault = rsp_now.fault;
        if (fetch_req) rsp_d.data = rsp_now.data;
      end

      always_ff @(posedge clk) begin
        if (reset) rsp_q <= '{data: NOP_WORD, valid: 1'b0, fault: 1'b0};
        else       rsp_q <= rsp_d;
      end

      assign instruction_code = rsp_q.data;
      assign instr_valid      = rsp_q.valid;
      assign fetch_fault      = rsp_q.fault;
    end
  endgenerate

endmodule
